seq_recognizer_bank: RTL and testbench
======================================

# seq_recognizer_bank

Parametrised bank of serial sequence recognizers for the virtual chip. It replaces the fixed single-channel 8-bit recognizer with `NCH` independent channels. Each channel matches a programmable `LEN`-bit pattern. Each channel has selectable overlapping or non-overlapping detection and a saturating hit counter. The bank sits behind the virtual chip pins and is driven at the tester's sample rate through a common enable strobe.

## Interface

Parameters:
- `NCH`, 4: number of independent channels.
- `LEN`, 8: pattern length in bits. Must be at least 2.
- `CNT_W`, 8: width of each hit counter.
- `PATTERN`, `8'hB6`: `LEN`-bit target pattern, shared by all channels. Bit `LEN-1` is the first bit received.

Ports:
- `clk`, input, 1: system clock from the FPGA tester.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `en`, input, 1: sample strobe. `din` is sampled only on edges where `en`=1.
- `din`, input, `NCH`: serial data, one bit per channel.
- `overlap`, input, 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `clr`, input, 1: synchronous clear of all channel state.
- `match`, output, `NCH`: one-cycle pulse per channel on a detected pattern.
- `hit_cnt`, output, `NCH*CNT_W`: per-channel hit counters. Channel i occupies bits `[i*CNT_W +: CNT_W]`.
- `cnt_sat`, output, `NCH`: per-channel flag, 1 while the counter equals its maximum value (2^`CNT_W`-1).

## Operation

Per-channel state:
- `sr`: `LEN`-bit shift register.
- `fill`: counter from 0 to `LEN`, saturating at `LEN`.
- `match` register.
- `hit_cnt` register.

Reset (`rst_n`=0), effective immediately and asynchronously:
- `sr`, `fill`, `match` and `hit_cnt` all go to 0.
- `cnt_sat` therefore reads 0.

On each edge, in priority order:
1. If `clr`=1: clear `sr`, `fill`, `match` and `hit_cnt` to 0. `en` is ignored on that edge.
2. Else if `en`=1, compute the next values:
   - `sr_n` = {`sr`[`LEN`-2:0], `din`[i]}.
   - `fill_n` = min(`fill`+1, `LEN`).
   - `hit` = (`sr_n` == `PATTERN`) && (`fill_n` == `LEN`).
   Then register:
   - `sr` <= `sr_n`.
   - `match` <= `hit`.
   - If `hit` and `overlap`=0: `fill` <= 0, so the next match needs `LEN` fresh bits. Otherwise `fill` <= `fill_n`.
   - If `hit` and `hit_cnt` is below its maximum: `hit_cnt` increments by 1. At the maximum it holds.
3. Else (`en`=0): `sr`, `fill` and `hit_cnt` hold, and `match` <= 0.

Additional rules:
- No match is reported before `LEN` bits have been sampled since reset, clear, or a non-overlapping hit. This holds even if `PATTERN` is all zeros.
- `overlap` is sampled on every edge with `en`=1. A mode change affects only hits evaluated after the change; it never retroactively alters `fill`.
- Channels are fully independent. Simultaneous hits on several channels all pulse in the same cycle.

## Timing

- Latency: the bit completing the pattern is sampled at edge k. `match` is high from edge k to edge k+1, and `hit_cnt` shows the new value from edge k.
- `match` is never high for more than one cycle per hit. Back-to-back hits on consecutive `en` edges (possible in overlap mode) produce a continuously high `match`, counted once per edge.
- `cnt_sat` is combinational from `hit_cnt`; it has no added latency.
- `en` may be held at 1 continuously, giving one sample per clock.

## Structure

- Shared package `vchip_pkg` holds:
  - the default constants `VCHIP_NCH`, `VCHIP_LEN`, `VCHIP_CNT_W`, `VCHIP_PATTERN`;
  - a `det_mode_e` enum (`DET_NONOVL`, `DET_OVL`) used by benches.
- Sub-module `seq_recognizer` implements one channel: `sr`, `fill`, `match` and the counter.
- The top level generates `NCH` instances of `seq_recognizer` and packs `hit_cnt`.

## Test plan

1. Exact match, `NCH`=4, `PATTERN`=`8'hB6`. Drive channel 0 with 10110110 and `en`=1 throughout. Required response:
   - `match`[0] pulses once, one cycle after the 8th bit.
   - `hit_cnt`[0]=1.
   - Channels 1-3 stay at 0.
2. Overlap, `PATTERN`=`8'hAA`, `overlap`=1. Drive 1010101010. Required response: matches after bits 8 and 10, `hit_cnt`=2.
3. Non-overlap, same stream as scenario 2 with `overlap`=0. Required response:
   - A single match after bit 8, `hit_cnt`=1.
   - Continuing the stream to 16 bits gives the second match after bit 16.
4. Counter saturation, `CNT_W`=2. Produce 5 hits. Required response: `hit_cnt`=3 and `cnt_sat`=1 after the 3rd hit, unchanged after the 5th.
5. `en` gaps and reset mid-stream:
   - Insert `en`=0 cycles between the bits of 10110110. Required response: the match still occurs after the 8th enabled bit.
   - Assert `rst_n`=0 after 7 bits. Required response: all outputs are 0 immediately, and a subsequent 1-bit completion does not match; 8 new bits are needed.
6. `clr` collision: assert `clr` on the same edge as `en` carrying the completing bit. Required response: no match, `hit_cnt`=0, `fill`=0.

Source files
------------

// File: rtl/vchip_pkg.sv
// Shared constants and types for the virtual-chip sequence recognizer bank.
// Defaults match the single-channel 8-bit recognizer this bank replaces.
package vchip_pkg;

  localparam int         VCHIP_NCH     = 4;
  localparam int         VCHIP_LEN     = 8;
  localparam int         VCHIP_CNT_W   = 8;
  localparam logic [7:0] VCHIP_PATTERN = 8'hB6;

  typedef enum logic {
    DET_NONOVL = 1'b0,
    DET_OVL    = 1'b1
  } det_mode_e;

endpackage

// File: rtl/seq_recognizer.sv
// One recognizer channel: shift register, fill counter, match pulse and a
// saturating hit counter. Bit LEN-1 of PATTERN is the first bit received.
module seq_recognizer
  import vchip_pkg::*;
#(
  parameter int             LEN     = VCHIP_LEN,
  parameter int             CNT_W   = VCHIP_CNT_W,
  parameter logic [LEN-1:0] PATTERN = LEN'(VCHIP_PATTERN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

  logic [LEN-1:0]    r_sr;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [CNT_W-1:0]  r_hit_cnt;

  logic [LEN-1:0]    w_sr_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_hit;
  logic              w_cnt_max;

  assign w_sr_n    = {r_sr[LEN-2:0], din};
  assign w_fill_n  = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  // The fill qualifier keeps an all-zero pattern from matching a freshly cleared sr.
  assign w_hit     = (w_sr_n == PATTERN) && (w_fill_n == FILL_FULL);
  assign w_cnt_max = &r_hit_cnt;

  // NOTE: every state register uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking here would chain them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_hit_cnt <= '0;
    end else if (clr) begin
      r_sr      <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_hit_cnt <= '0;
    end else if (en) begin
      r_sr    <= w_sr_n;
      r_match <= w_hit;
      r_fill  <= (w_hit && !overlap) ? '0 : w_fill_n;
      if (w_hit && !w_cnt_max) r_hit_cnt <= r_hit_cnt + 1'b1;
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match   = r_match;
  assign hit_cnt = r_hit_cnt;
  assign cnt_sat = w_cnt_max;

endmodule

// File: rtl/seq_recognizer_bank.sv
// NCH independent recognizer channels sharing one pattern, strobe and mode.
// Channel i's counter occupies hit_cnt[i*CNT_W +: CNT_W].
module seq_recognizer_bank
  import vchip_pkg::*;
#(
  parameter int             NCH     = VCHIP_NCH,
  parameter int             LEN     = VCHIP_LEN,
  parameter int             CNT_W   = VCHIP_CNT_W,
  parameter logic [LEN-1:0] PATTERN = LEN'(VCHIP_PATTERN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       din,
  input  logic                 overlap,
  input  logic                 clr,
  output logic [NCH-1:0]       match,
  output logic [NCH*CNT_W-1:0] hit_cnt,
  output logic [NCH-1:0]       cnt_sat
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    seq_recognizer #(
      .LEN    (LEN),
      .CNT_W  (CNT_W),
      .PATTERN(PATTERN)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .din    (din[i]),
      .overlap(overlap),
      .clr    (clr),
      .match  (match[i]),
      .hit_cnt(hit_cnt[i*CNT_W +: CNT_W]),
      .cnt_sat(cnt_sat[i])
    );
  end

endmodule

// File: tb/tb_seq_recognizer_bank.sv
// Directed bench for seq_recognizer_bank: a default 4-channel 0xB6 bank and a
// 2-channel 0xAA bank with 2-bit counters for overlap and saturation cases.
module tb_seq_recognizer_bank;
  import vchip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  det_mode_e   mode = DET_OVL;
  logic        overlap;
  logic [3:0]  din_a = '0;
  logic [1:0]  din_b = '0;

  logic [3:0]  match_a;
  logic [31:0] hit_cnt_a;
  logic [3:0]  cnt_sat_a;
  logic [1:0]  match_b;
  logic [3:0]  hit_cnt_b;
  logic [1:0]  cnt_sat_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pa = 8'hB6;

  assign overlap = mode;

  always #5 clk = ~clk;

  seq_recognizer_bank dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a), .overlap(overlap), .clr(clr),
    .match(match_a), .hit_cnt(hit_cnt_a), .cnt_sat(cnt_sat_a)
  );

  seq_recognizer_bank #(.NCH(2), .LEN(8), .CNT_W(2), .PATTERN(8'hAA)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b), .overlap(overlap), .clr(clr),
    .match(match_b), .hit_cnt(hit_cnt_b), .cnt_sat(cnt_sat_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle on the falling edge, then settle just after the rising edge.
  task automatic step(input logic e, input logic c, input logic [3:0] da, input logic [1:0] db);
    @(negedge clk);
    en    = e;
    clr   = c;
    din_a = da;
    din_b = db;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic b;

    #12;
    check("rst_match", 32'(match_a), 32'h0);
    check("rst_cnt", hit_cnt_a, 32'h0);
    check("rst_sat", 32'(cnt_sat_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exact 0xB6 on channel 0
    mode = DET_OVL;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, {3'b000, pa[7-i]}, 2'b00);
      check("s1_match", 32'(match_a), (i == 7) ? 32'h1 : 32'h0);
    end
    check("s1_cnt", hit_cnt_a, 32'h0000_0001);
    check("s1_sat", 32'(cnt_sat_a), 32'h0);
    step(1'b1, 1'b0, 4'h0, 2'b00);
    check("s1_pulse", 32'(match_a), 32'h0);
    check("s1_hold", hit_cnt_a, 32'h0000_0001);

    // Overlap, 0xAA, 10 bits: hits on bits 8 and 10
    step(1'b0, 1'b1, 4'h0, 2'b00);
    mode = DET_OVL;
    for (int i = 0; i < 10; i++) begin
      b = ~i[0];
      step(1'b1, 1'b0, 4'h0, {1'b0, b});
      check("s2_match", 32'(match_b), (i == 7 || i == 9) ? 32'h1 : 32'h0);
    end
    check("s2_cnt", 32'(hit_cnt_b), 32'h2);

    // Non-overlap, 16 bits: hits on bits 8 and 16
    step(1'b0, 1'b1, 4'h0, 2'b00);
    mode = DET_NONOVL;
    for (int i = 0; i < 16; i++) begin
      b = ~i[0];
      step(1'b1, 1'b0, 4'h0, {1'b0, b});
      check("s3_match", 32'(match_b), (i == 7 || i == 15) ? 32'h1 : 32'h0);
      if (i == 9) check("s3_cnt10", 32'(hit_cnt_b), 32'h1);
    end
    check("s3_cnt16", 32'(hit_cnt_b), 32'h2);

    // Saturation: five overlapping hits into a 2-bit counter
    step(1'b0, 1'b1, 4'h0, 2'b00);
    mode = DET_OVL;
    for (int i = 0; i < 16; i++) begin
      b = ~i[0];
      step(1'b1, 1'b0, 4'h0, {1'b0, b});
      check("s4_match", 32'(match_b), (i >= 7 && i[0]) ? 32'h1 : 32'h0);
      if (i == 11) begin
        check("s4_cnt3", 32'(hit_cnt_b), 32'h3);
        check("s4_sat3", 32'(cnt_sat_b), 32'h1);
      end
    end
    check("s4_cnt5", 32'(hit_cnt_b), 32'h3);
    check("s4_sat5", 32'(cnt_sat_b), 32'h1);

    // en gaps between pattern bits
    step(1'b0, 1'b1, 4'h0, 2'b00);
    mode = DET_NONOVL;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, {3'b000, pa[7-i]}, 2'b00);
      check("s5_match", 32'(match_a), (i == 7) ? 32'h1 : 32'h0);
      step(1'b0, 1'b0, 4'hF, 2'b11);
      check("s5_gap", 32'(match_a), 32'h0);
    end
    check("s5_cnt", hit_cnt_a, 32'h0000_0001);

    // Asynchronous reset after 7 bits
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, {3'b000, pa[7-i]}, 2'b00);
      check("s5_pre", 32'(match_a), 32'h0);
    end
    check("s5_precnt", hit_cnt_a, 32'h0000_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_match", 32'(match_a), 32'h0);
    check("s5_rst_cnt", hit_cnt_a, 32'h0);
    check("s5_rst_sat", 32'(cnt_sat_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, {3'b000, pa[0]}, 2'b00);
    check("s5_nocomp", 32'(match_a), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, {3'b000, pa[7-i]}, 2'b00);
      check("s5_refill", 32'(match_a), (i == 7) ? 32'h1 : 32'h0);
    end
    check("s5_refcnt", hit_cnt_a, 32'h0000_0001);

    // clr on the same edge as the completing bit
    step(1'b0, 1'b1, 4'h0, 2'b00);
    mode = DET_OVL;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, {3'b000, pa[7-i]}, 2'b00);
    end
    step(1'b1, 1'b1, {3'b000, pa[0]}, 2'b00);
    check("s6_match", 32'(match_a), 32'h0);
    check("s6_cnt", hit_cnt_a, 32'h0);
    check("s6_fill", 32'(dut_a.g_ch[0].u_ch.r_fill), 32'h0);
    check("s6_sr", 32'(dut_a.g_ch[0].u_ch.r_sr), 32'h0);

    // Simultaneous hits on channels 1 and 3
    step(1'b0, 1'b1, 4'h0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, {pa[7-i], 1'b0, pa[7-i], 1'b0}, 2'b00);
      check("s7_match", 32'(match_a), (i == 7) ? 32'hA : 32'h0);
    end
    check("s7_cnt", hit_cnt_a, 32'h0100_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
